otter_cu_fsm: RTL and testbench

Multicycle control state machine for the OTTER MCU. Sequences each instruction through fetch, execute, optional load writeback and interrupt entry, and drives the enables for the PC, register file, memory and CSR file. Immediates come from the immediate generator and operand selects from the combinational decoder. Memory accesses use a ready handshake, so instruction and data memories may insert wait states.

---
 rtl/otter_cu_fsm_pkg.sv | 29 ++
 rtl/otter_cu_fsm.sv | 114 +++++++++++
 tb/tb_otter_cu_fsm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/otter_cu_fsm_pkg.sv
// Shared types for the OTTER multicycle control unit: state encoding,
// RV32I major opcodes and the funct3 value that selects MRET.
package otter_pkg;

   typedef enum logic [2:0] {
      INIT,
      FETCH,
      EXEC,
      WB,
      INTR
   } cu_state_t;

   typedef enum logic [6:0] {
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      BRANCH = 7'b1100011,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      OP     = 7'b0110011,
      OP_IMM = 7'b0010011,
      SYSTEM = 7'b1110011,
      FENCE  = 7'b0001111
   } opcode_t;

   localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: fetch / execute / load writeback / interrupt
// entry, with ready-handshaked memory accesses and Mealy-decoded enables.
module otter_cu_fsm
   import otter_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       intr,
   input  logic       csr_mie,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       regWrite,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       memWE2,
   output logic       reset,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec
);

   cu_state_t r_state;
   cu_state_t w_next;
   cu_state_t w_done_next;

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= INIT;
      else        r_state <= w_next;
   end

   // Interrupts are only examined at instruction completion.
   assign w_done_next = (intr && csr_mie) ? INTR : FETCH;

   always_comb begin
      w_next    = r_state;
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      memWE2    = 1'b0;
      reset     = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;

      case (r_state)
         INIT: begin
            reset  = 1'b1;
            w_next = FETCH;
         end

         FETCH: begin
            memRDEN1 = 1'b1;
            if (mem_ready) w_next = EXEC;
         end

         EXEC: begin
            case (opcode)
               LOAD: begin
                  memRDEN2 = 1'b1;
                  if (mem_ready) w_next = WB;
               end
               STORE: begin
                  memWE2 = 1'b1;
                  if (mem_ready) begin
                     PCWrite = 1'b1;
                     w_next  = w_done_next;
                  end
               end
               BRANCH: begin
                  PCWrite = 1'b1;
                  w_next  = w_done_next;
               end
               OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                  PCWrite  = 1'b1;
                  regWrite = 1'b1;
                  w_next   = w_done_next;
               end
               SYSTEM: begin
                  PCWrite = 1'b1;
                  if (func3 == F3_MRET) begin
                     mret_exec = 1'b1;
                  end else begin
                     csr_WE   = 1'b1;
                     regWrite = 1'b1;
                  end
                  w_next = w_done_next;
               end
               default: begin
                  PCWrite = 1'b1;
                  w_next  = w_done_next;
               end
            endcase
         end

         WB: begin
            regWrite = 1'b1;
            PCWrite  = 1'b1;
            w_next   = w_done_next;
         end

         INTR: begin
            int_taken = 1'b1;
            PCWrite   = 1'b1;
            w_next    = FETCH;
         end

         default: w_next = INIT;
      endcase
   end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: per-cycle output vectors against
// hand-computed expectations.
module tb_otter_cu_fsm;
   import otter_pkg::*;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       intr;
   logic       csr_mie;
   logic       mem_ready;
   logic       PCWrite, regWrite, memRDEN1, memRDEN2, memWE2;
   logic       reset, csr_WE, int_taken, mret_exec;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // {PCWrite, regWrite, memRDEN1, memRDEN2, memWE2, reset, csr_WE, int_taken, mret_exec}
   localparam logic [8:0] O_RST    = 9'b000001000;
   localparam logic [8:0] O_FETCH  = 9'b001000000;
   localparam logic [8:0] O_ALU    = 9'b110000000;
   localparam logic [8:0] O_PC     = 9'b100000000;
   localparam logic [8:0] O_LD     = 9'b000100000;
   localparam logic [8:0] O_ST     = 9'b000010000;
   localparam logic [8:0] O_STDONE = 9'b100010000;
   localparam logic [8:0] O_WB     = 9'b110000000;
   localparam logic [8:0] O_INTR   = 9'b100000010;
   localparam logic [8:0] O_MRET   = 9'b100000001;
   localparam logic [8:0] O_CSR    = 9'b110000100;

   otter_cu_fsm u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .opcode    (opcode),
      .func3     (func3),
      .intr      (intr),
      .csr_mie   (csr_mie),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .regWrite  (regWrite),
      .memRDEN1  (memRDEN1),
      .memRDEN2  (memRDEN2),
      .memWE2    (memWE2),
      .reset     (reset),
      .csr_WE    (csr_WE),
      .int_taken (int_taken),
      .mret_exec (mret_exec)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // Apply inputs for one cycle, check the decoded outputs mid-cycle, then
   // advance to just after the next rising edge.
   task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic rdy, input logic ir, input logic mie,
                       input logic [8:0] exp);
      opcode    = op;
      func3     = f3;
      mem_ready = rdy;
      intr      = ir;
      csr_mie   = mie;
      #2;
      check_eq(tag, {PCWrite, regWrite, memRDEN1, memRDEN2, memWE2,
                     reset, csr_WE, int_taken, mret_exec}, exp);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N = 1'b0; opcode = '0; func3 = '0; intr = 1'b0; csr_mie = 1'b0; mem_ready = 1'b1;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      step("init",        7'b0,   3'b000, 1'b1, 1'b0, 1'b0, O_RST);
      step("fetch1",      OP_IMM, 3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("addi_exec",   OP_IMM, 3'b000, 1'b1, 1'b0, 1'b0, O_ALU);
      step("fetch_stall", LOAD,   3'b010, 1'b0, 1'b0, 1'b0, O_FETCH);
      step("fetch_done",  LOAD,   3'b010, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("lw_wait1",    LOAD,   3'b010, 1'b0, 1'b0, 1'b0, O_LD);
      step("lw_wait2",    LOAD,   3'b010, 1'b0, 1'b0, 1'b0, O_LD);
      step("lw_done",     LOAD,   3'b010, 1'b1, 1'b0, 1'b0, O_LD);
      step("lw_wb",       LOAD,   3'b010, 1'b0, 1'b0, 1'b0, O_WB);
      step("fetch_sw",    STORE,  3'b010, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("sw_wait",     STORE,  3'b010, 1'b0, 1'b0, 1'b0, O_ST);
      step("sw_done",     STORE,  3'b010, 1'b1, 1'b0, 1'b0, O_STDONE);
      step("fetch_beq",   BRANCH, 3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("beq_intr",    BRANCH, 3'b000, 1'b1, 1'b1, 1'b1, O_PC);
      step("intr_entry",  BRANCH, 3'b000, 1'b1, 1'b1, 1'b1, O_INTR);
      step("fetch_noint", BRANCH, 3'b000, 1'b1, 1'b1, 1'b1, O_FETCH);
      step("beq_mie0",    BRANCH, 3'b000, 1'b1, 1'b1, 1'b0, O_PC);
      step("fetch_mret",  SYSTEM, 3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("mret_exec",   SYSTEM, 3'b000, 1'b1, 1'b1, 1'b0, O_MRET);
      step("fetch_csr",   SYSTEM, 3'b001, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("csrrw_exec",  SYSTEM, 3'b001, 1'b1, 1'b0, 1'b0, O_CSR);
      step("fetch_undef", 7'b0,   3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("undef_nop",   7'b0,   3'b000, 1'b1, 1'b0, 1'b0, O_PC);
      step("fetch_jal",   JAL,    3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("jal_exec",    JAL,    3'b000, 1'b1, 1'b0, 1'b0, O_ALU);
      step("fetch_fence", FENCE,  3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("fence_nop",   FENCE,  3'b000, 1'b1, 1'b0, 1'b0, O_PC);
      step("fetch_lw2",   LOAD,   3'b010, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("lw_no_intr",  LOAD,   3'b010, 1'b1, 1'b1, 1'b1, O_LD);
      step("wb_intr",     LOAD,   3'b010, 1'b1, 1'b1, 1'b1, O_WB);
      step("intr_after",  LOAD,   3'b010, 1'b1, 1'b1, 1'b1, O_INTR);
      step("fetch_sw2",   STORE,  3'b010, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("sw_intr",     STORE,  3'b010, 1'b1, 1'b1, 1'b1, O_STDONE);
      step("intr_sw",     STORE,  3'b010, 1'b1, 1'b0, 1'b0, O_INTR);

      RST_N = 1'b0;
      step("fetch_rst",   OP,     3'b000, 1'b0, 1'b0, 1'b0, O_FETCH);
      RST_N = 1'b1;
      step("init_again",  OP,     3'b000, 1'b0, 1'b0, 1'b0, O_RST);
      step("fetch_post",  OP,     3'b000, 1'b1, 1'b0, 1'b0, O_FETCH);
      step("op_exec",     OP,     3'b000, 1'b1, 1'b0, 1'b0, O_ALU);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
